score_bcd_converter: RTL



---
 rtl/score_bcd_converter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/score_bcd_converter.sv
// score_bcd_converter: sequential binary-to-BCD converter (shift-and-add-3), one shift per clock.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   start     conversion request, accepted in idle and in the publish cycle
//   bin       binary value, captured on the accepting edge only
//   busy      high while shifting
//   done      one-cycle pulse, coincident with the new bcd/overflow values
//   bcd       packed digits, [3:0] is the ones digit
//   overflow  last converted value did not fit in DIGITS decimal digits
module score_bcd_converter #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   shreg_q, shreg_d;
  logic [BcdW-1:0]   scratch_q, scratch_d;
  logic [BcdW-1:0]   scratch_adj;
  logic              trk_q, trk_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              shift_out;

  // Add-3 correction on every nibble in parallel before the shift.
  always_comb begin
    scratch_adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] +
                              ((scratch_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    trk_d     = trk_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    shift_out = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) begin
          // Publish all outputs in one edge so the display never sees a partial value.
          bcd_d  = scratch_q;
          ovf_d  = trk_q;
          done_d = 1'b1;
        end
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          trk_d     = 1'b0;
          cnt_d     = CntW'(IN_W);
          state_d   = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        {shift_out, scratch_d, shreg_d} = {scratch_adj, shreg_q, 1'b0};
        // Any bit leaving the top digit means the value needs more than DIGITS digits.
        trk_d = trk_q | shift_out;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      scratch_q <= '0;
      trk_q     <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      trk_q     <= trk_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q == StShift);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule
